// File: rtl/bridge_pkg.sv
// bridge_pkg: shared state encoding, default slave address map and helpers for the bus bridge
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [31:0] DM_LO   = 32'h0000_0000;
    localparam logic [31:0] DM_HI   = 32'h0000_2fff;
    localparam logic [31:0] TIM0_LO = 32'h0000_7f00;
    localparam logic [31:0] TIM0_HI = 32'h0000_7f0b;
    localparam logic [31:0] TIM1_LO = 32'h0000_7f10;
    localparam logic [31:0] TIM1_HI = 32'h0000_7f1b;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (oh[i]) idx = i[2:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/bridge_addr_decoder.sv
// bridge_addr_decoder: combinational address-range decode to a one-hot slave select
//   addr       in  ADDR_W  byte address to decode
//   hit_onehot out N_SLV   one-hot hit, lowest index wins on overlapping ranges
//   miss       out 1       no range contains addr
module bridge_addr_decoder
    import bridge_pkg::*;
#(
    parameter int N_SLV  = 3,
    parameter int ADDR_W = 32,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_LO = {TIM1_LO, TIM0_LO, DM_LO},
    parameter logic [N_SLV*ADDR_W-1:0] SLV_HI = {TIM1_HI, TIM0_HI, DM_HI}
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [N_SLV-1:0]  hit_onehot,
    output logic              miss
);

    logic [N_SLV-1:0] hit;

    for (genvar g = 0; g < N_SLV; g++) begin : g_cmp
        assign hit[g] = (addr >= SLV_LO[g*ADDR_W +: ADDR_W]) && (addr <= SLV_HI[g*ADDR_W +: ADDR_W]);
    end

    // Isolate the lowest set bit so overlapping ranges resolve to the lowest index.
    assign hit_onehot = hit & ~(hit - N_SLV'(1));
    assign miss       = ~|hit;

endmodule

// File: rtl/multi_slave_bus_bridge.sv
// multi_slave_bus_bridge: one-at-a-time CPU to N_SLV slave bridge with timeout error and irq synchronisers
//   clk, reset_n                          clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata/be              CPU request, held until cpu_ready
//   cpu_ready/rdata/err                   one-cycle completion with registered read data and error
//   slv_sel/we/addr/wdata/be              one-hot select plus latched, broadcast access fields
//   slv_ready/rdata                       per-slave completion and packed read data
//   slv_irq -> irq_out                    raw interrupts through a two-flop synchroniser
module multi_slave_bus_bridge
    import bridge_pkg::*;
#(
    parameter int N_SLV  = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_LO = {TIM1_LO, TIM0_LO, DM_LO},
    parameter logic [N_SLV*ADDR_W-1:0] SLV_HI = {TIM1_HI, TIM0_HI, DM_HI},
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [DATA_W-1:0]       cpu_wdata,
    input  logic [DATA_W/8-1:0]     cpu_be,
    output logic                    cpu_ready,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic                    cpu_err,
    output logic [N_SLV-1:0]        slv_sel,
    output logic                    slv_we,
    output logic [ADDR_W-1:0]       slv_addr,
    output logic [DATA_W-1:0]       slv_wdata,
    output logic [DATA_W/8-1:0]     slv_be,
    input  logic [N_SLV-1:0]        slv_ready,
    input  logic [N_SLV*DATA_W-1:0] slv_rdata,
    input  logic [N_SLV-1:0]        slv_irq,
    output logic [N_SLV-1:0]        irq_out
);

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [N_SLV-1:0]    sel_q, sel_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] be_q, be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [N_SLV-1:0]    irq_meta_q, irq_q;
    logic [N_SLV-1:0]    hit;
    logic                miss;
    logic                ack;
    logic [DATA_W-1:0]   rd_sel;

    bridge_addr_decoder #(
        .N_SLV (N_SLV),
        .ADDR_W(ADDR_W),
        .SLV_LO(SLV_LO),
        .SLV_HI(SLV_HI)
    ) u_dec (
        .addr      (cpu_addr),
        .hit_onehot(hit),
        .miss      (miss)
    );

    // Only the selected slave's ready counts; others are masked off.
    assign ack = |(slv_ready & sel_q);

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (sel_q[i]) rd_sel = slv_rdata[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cpu_req && miss) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (cpu_req) begin
                    state_d = ACCESS;
                    sel_d   = hit;
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    be_d    = cpu_be;
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                if (ack || cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    err_d   = ~ack;
                    rdata_d = (ack && !we_q) ? rd_sel : '0;
                    sel_d   = '0;
                    we_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            irq_meta_q <= '0;
            irq_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            irq_meta_q <= slv_irq;
            irq_q      <= irq_meta_q;
        end
    end

    // err is only meaningful alongside cpu_ready, so it is masked outside DONE.
    assign cpu_ready = (state_q == DONE);
    assign cpu_err   = err_q & cpu_ready;
    assign cpu_rdata = rdata_q;
    assign slv_sel   = sel_q;
    assign slv_we    = we_q;
    assign slv_addr  = addr_q;
    assign slv_wdata = wdata_q;
    assign slv_be    = be_q;
    assign irq_out   = irq_q;

endmodule

// File: tb/tb_multi_slave_bus_bridge.sv
// tb_multi_slave_bus_bridge: table-driven bench with a completion scoreboard for multi_slave_bus_bridge
module tb_multi_slave_bus_bridge;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0]  cpu_be = '0;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic [2:0]  slv_sel;
    logic        slv_we;
    logic [31:0] slv_addr;
    logic [31:0] slv_wdata;
    logic [3:0]  slv_be;
    logic [2:0]  slv_ready = '0;
    logic [95:0] slv_rdata = '0;
    logic [2:0]  slv_irq = '0;
    logic [2:0]  irq_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wait_n = 0;
    logic [2:0] noise = '0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          wait_n;
        logic [2:0]  noise;
        logic [31:0] rd;
        logic [2:0]  sel;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          selc;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];

    multi_slave_bus_bridge dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_be   (cpu_be),
        .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata),
        .cpu_err  (cpu_err),
        .slv_sel  (slv_sel),
        .slv_we   (slv_we),
        .slv_addr (slv_addr),
        .slv_wdata(slv_wdata),
        .slv_be   (slv_be),
        .slv_ready(slv_ready),
        .slv_rdata(slv_rdata),
        .slv_irq  (slv_irq),
        .irq_out  (irq_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave model: selected slave answers after wait_n wait cycles; noise bits toggle on unselected slaves.
    initial forever begin
        int acc_n;
        @(posedge clk);
        #1;
        if (slv_sel != 3'b000) begin
            slv_ready = ((acc_n == wait_n) ? slv_sel : 3'b000) | (noise & {3{acc_n[0]}});
            acc_n++;
        end else begin
            slv_ready = '0;
            acc_n = 0;
        end
    end

    // Completion scoreboard.
    always @(negedge clk) begin
        if (reset_n && cpu_ready) begin : mon
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got cpu_ready=1 expected 0");
            end else begin
                e = sb.pop_front();
                check("cpu_err", 64'(cpu_err), 64'(e.err));
                check("cpu_rdata", 64'(cpu_rdata), 64'(e.rdata));
                check("ready_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        int nsel;
        logic done;
        @(posedge clk);
        #1;
        cpu_req = 1'b1;
        cpu_we = v.we;
        cpu_addr = v.addr;
        cpu_wdata = v.wdata;
        cpu_be = v.be;
        wait_n = v.wait_n;
        noise = v.noise;
        slv_rdata = {v.rd + 32'd2, v.rd + 32'd1, v.rd};
        e.err = v.err;
        e.rdata = v.rdata;
        e.cyc = cyc + v.lat;
        sb.push_back(e);
        nsel = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (i == 1) check("slv_sel_first", 64'(slv_sel), 64'(v.sel));
            if (slv_sel != 3'b000) begin
                nsel++;
                check("slv_sel_hold", 64'(slv_sel), 64'(v.sel));
                check("slv_we", 64'(slv_we), 64'(v.we));
                check("slv_addr", 64'(slv_addr), 64'(v.addr));
                check("slv_wdata", 64'(slv_wdata), 64'(v.wdata));
                check("slv_be", 64'(slv_be), 64'(v.be));
            end
            if (cpu_ready) done = 1'b1;
        end
        check("ready_seen", 64'(done), 64'd1);
        check("sel_cycles", 64'(nsel), 64'(v.selc));
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        noise = '0;
        @(negedge clk);
        check("ready_pulse_end", 64'(cpu_ready), 64'd0);
        check("rdata_hold", 64'(cpu_rdata), 64'(v.rdata));
    endtask

    initial begin
        vecs[0] = '{32'h0000_1000, 1'b0, 32'h0, 4'hF, 0, 3'b000, 32'hCAFE_0001, 3'b001, 1'b0, 32'hCAFE_0001, 2, 1};
        vecs[1] = '{32'h0000_7f14, 1'b1, 32'hFF, 4'hF, 3, 3'b000, 32'h0, 3'b100, 1'b0, 32'h0, 5, 4};
        vecs[2] = '{32'h0000_7f0c, 1'b0, 32'h0, 4'hF, 0, 3'b000, 32'hDEAD_BEEF, 3'b000, 1'b1, 32'h0, 1, 0};
        vecs[3] = '{32'h0000_7f00, 1'b0, 32'h0, 4'hF, 255, 3'b000, 32'h5555_0000, 3'b010, 1'b1, 32'h0, 16, 15};
        vecs[4] = '{32'h0000_0004, 1'b0, 32'h0, 4'hF, 14, 3'b010, 32'hABCD_0000, 3'b001, 1'b0, 32'hABCD_0000, 16, 15};
        vecs[5] = '{32'h0000_7f0b, 1'b0, 32'h0, 4'hF, 1, 3'b000, 32'h1111_0000, 3'b010, 1'b0, 32'h1111_0001, 3, 2};
        vecs[6] = '{32'h0000_2fff, 1'b1, 32'hA5A5_5A5A, 4'h3, 0, 3'b000, 32'h77, 3'b001, 1'b0, 32'h0, 2, 1};
        vecs[7] = '{32'h0000_3000, 1'b1, 32'h1, 4'hF, 0, 3'b000, 32'h1, 3'b000, 1'b1, 32'h0, 1, 0};
        vecs[8] = '{32'h0000_7f10, 1'b0, 32'h0, 4'hF, 2, 3'b000, 32'h0000_0020, 3'b100, 1'b0, 32'h0000_0022, 4, 3};
        vecs[9] = '{32'h0000_7f1c, 1'b0, 32'h0, 4'hF, 0, 3'b000, 32'h0, 3'b000, 1'b1, 32'h0, 1, 0};

        @(negedge clk);
        check("rst_ready", 64'(cpu_ready), 64'd0);
        check("rst_err", 64'(cpu_err), 64'd0);
        check("rst_sel", 64'(slv_sel), 64'd0);
        check("rst_we", 64'(slv_we), 64'd0);
        check("rst_rdata", 64'(cpu_rdata), 64'd0);
        check("rst_addr", 64'(slv_addr), 64'd0);
        check("rst_irq", 64'(irq_out), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int k = 0; k < 10; k++) run_vec(vecs[k]);

        // Reset while a timer access is waiting: abort with no completion.
        @(posedge clk);
        #1;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 32'h0000_7f00;
        wait_n = 255;
        repeat (3) @(negedge clk);
        check("pre_reset_sel", 64'(slv_sel), 64'(3'b010));
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_sel", 64'(slv_sel), 64'd0);
        check("abort_ready", 64'(cpu_ready), 64'd0);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_ready_hold", 64'(cpu_ready), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_vec(vecs[0]);

        // Interrupt pulse through the synchroniser.
        @(posedge clk);
        #1;
        slv_irq = 3'b010;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            check("irq_out", 64'(irq_out), 64'((c >= 2 && c <= 6) ? 3'b010 : 3'b000));
            if (c == 4) begin
                @(posedge clk);
                #1;
                slv_irq = 3'b000;
            end
        end

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
